// File: rtl/freq_meter.sv
// Gate-window frequency counter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Result registered on window end with a one-cycle valid strobe; no backpressure, start ignored while busy.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]      LAST_GATE = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [31:0]      r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;

    logic             w_edge;
    logic             w_gate_last;
    logic             w_cnt_full;
    logic             w_restart;
    logic             w_gate_end;
    logic [CNT_W-1:0] w_edge_cnt_nxt;
    logic             w_sat_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge      = r_s2 & ~r_s3;
    assign w_gate_last = (r_gate_cnt == LAST_GATE);
    assign w_cnt_full  = (r_edge_cnt == CNT_MAX);
    assign w_restart   = ((r_state == IDLE) && start) || ((r_state == DONE) && cont);
    assign w_gate_end  = (r_state == GATE) && w_gate_last;

    // An edge arriving at full scale is lost rather than wrapping; that loss is what ovf reports.
    assign w_edge_cnt_nxt = (w_edge && !w_cnt_full) ? (r_edge_cnt + CNT_W'(1)) : r_edge_cnt;
    assign w_sat_nxt      = r_sat | (w_edge & w_cnt_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = GATE;
            GATE:    if (w_gate_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = cont ? GATE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (w_restart) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (r_state == GATE) begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sat      <= w_sat_nxt;
        end
    end

    // Result takes the count including an edge seen in the final gate cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            freq  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= w_gate_end;
            if (w_gate_end) begin
                freq <= w_edge_cnt_nxt;
                ovf  <= w_sat_nxt;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, gives the gate window length in clk cycles (1 s at 100 MHz); legal range 2 to 2^32-1.
REQ-002 Parameter CNT_W, default 27, gives the width of the edge counter and of the result.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sig_in, input, 1 bit: the signal under measurement, asynchronous to clk.
REQ-006 Port start, input, 1 bit: level-sampled request to begin a measurement.
REQ-007 Port cont, input, 1 bit: when high, a new gate starts automatically after each result.
REQ-008 Port freq, output, CNT_W bits: rising edges of sig_in counted in the last completed gate window.
REQ-009 Port valid, output, 1 bit: one-cycle strobe marking a new freq/ovf result.
REQ-010 Port busy, output, 1 bit: high in states GATE and DONE.
REQ-011 Port ovf, output, 1 bit: high when the last result saturated.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus history flop s3; edge = s2 & ~s3.
REQ-013 The FSM SHALL have exactly three states: IDLE, GATE, DONE.
REQ-014 In IDLE with start=1, the next state SHALL be GATE, and edge_cnt and gate_cnt SHALL both clear to 0.
REQ-015 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-016 In GATE, gate_cnt SHALL increment every cycle; the FSM SHALL leave GATE on the cycle gate_cnt == GATE_CYCLES-1, so the window is exactly GATE_CYCLES cycles.
REQ-017 In GATE, each cycle with edge=1 SHALL increment edge_cnt, including the final gate cycle.
REQ-018 edge_cnt SHALL saturate at 2^CNT_W-1 and set an internal sat flag; it SHALL never wrap.
REQ-019 On the GATE-to-DONE transition, freq SHALL load the final count (including any edge in the last cycle) and ovf SHALL load sat.
REQ-020 In DONE, valid SHALL be 1 for exactly that one cycle.
REQ-021 From DONE, the next state SHALL be GATE when cont=1, with counters and sat cleared, and IDLE otherwise.
REQ-022 Edges arriving in IDLE or DONE SHALL NOT be counted.
REQ-023 In continuous mode there SHALL be exactly one dead cycle (DONE) between windows.
REQ-024 start asserted while busy=1 SHALL be ignored, with no restart and no effect on the window.
REQ-025 freq and ovf SHALL hold their values until the next DONE entry; no output other than valid may pulse.
REQ-026 Latency: start sampled in cycle 0 gives GATE in cycles 1..GATE_CYCLES, valid in cycle GATE_CYCLES+1, and freq usable from that same cycle.
REQ-027 Dropping cont during GATE SHALL still complete the current window; the cont level is sampled only in DONE.
REQ-028 Sensitivity: edges are counted accurately only when sig_in high and low phases each last at least 1 clk cycle, i.e. sig_in ≤ clk/2.

Reset
REQ-029 While reset=0, asynchronously: state=IDLE; s1=s2=s3=0; edge_cnt=0; gate_cnt=0; sat=0; freq=0; valid=0; ovf=0; busy=0.
REQ-030 A reset mid-GATE SHALL discard the partial count; after release the block waits in IDLE for start.
REQ-031 The first clk edge after reset release SHALL behave as a normal IDLE cycle.

Verification (GATE_CYCLES=100, CNT_W=8 unless noted)
REQ-032 sig_in period 10 clk, free-running; start pulse 1 cycle -> valid exactly 101 cycles after the start sample, freq=10, ovf=0, busy high 101 cycles.
REQ-033 sig_in held 0, start pulse -> freq=0, ovf=0, valid once; then with cont=0, IDLE with busy=0.
REQ-034 CNT_W=4, sig_in toggling every clk (50 edges/window) -> freq=15, ovf=1; a following run with period 10 -> freq=10, ovf=0.
REQ-035 cont=1, sig_in period 20 -> valid every 101 cycles, each freq=5; cont dropped mid-window -> that window completes, then IDLE.
REQ-036 reset=0 asserted 50 cycles into GATE -> all outputs 0 immediately with no valid; restart yields the full correct count of 10.
REQ-037 start held high through an entire window with cont=0 -> IDLE re-samples start, so a second window begins one cycle after DONE; start pulses during GATE cause no restart (valid spacing unchanged).
